// File: rtl/complex_accumulator_if.sv
// complex_accumulator_if
// Bundles the sample input, block-clear and result handshake of the
// integrate-and-dump stage.
//   Re_in, Im_in    signed IN_W products from the complex multiplier
//   data_valid_in   Re_in/Im_in valid this cycle
//   acc_clr         synchronous discard of the partial block
//   Re_out, Im_out  saturated signed OUT_W block sums
//   data_valid_out  result register holds an unconsumed result
//   out_ready       consumer takes the result when high with data_valid_out
//   sat_flag        current result had Re or Im saturated
//   overrun         sticky: an unconsumed result was overwritten
// master: the upstream producer / downstream consumer side.
// slave:  the accumulator itself.
interface complex_accumulator_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 18
);
    logic signed [IN_W-1:0]  Re_in;
    logic signed [IN_W-1:0]  Im_in;
    logic                    data_valid_in;
    logic                    acc_clr;
    logic signed [OUT_W-1:0] Re_out;
    logic signed [OUT_W-1:0] Im_out;
    logic                    data_valid_out;
    logic                    out_ready;
    logic                    sat_flag;
    logic                    overrun;

    modport master (
        output Re_in, Im_in, data_valid_in, acc_clr, out_ready,
        input  Re_out, Im_out, data_valid_out, sat_flag, overrun
    );

    modport slave (
        input  Re_in, Im_in, data_valid_in, acc_clr, out_ready,
        output Re_out, Im_out, data_valid_out, sat_flag, overrun
    );
endinterface

// File: rtl/complex_accumulator.sv
// complex_accumulator
// Integrate-and-dump of complex products: sums ACC_LEN valid samples per
// channel, saturates each block sum to OUT_W bits and holds it in a
// valid/ready result register.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  complex_accumulator_if.slave (samples in, results out, flags)
//
// state | meaning
// EMPTY | result register holds no unconsumed result
// FULL  | result register holds a result awaiting out_ready
module complex_accumulator #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 18,
    parameter int ACC_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    complex_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(ACC_LEN);
    localparam int ACC_W = IN_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] sum_re, sum_im;
    logic signed [OUT_W-1:0] sat_re, sat_im;
    logic                    hit_re, hit_im;
    logic                    take, dump;
    logic signed [OUT_W-1:0] re_q, im_q;
    logic                    sat_q, overrun_q;

    assign take   = bus.data_valid_in && !bus.acc_clr;
    assign dump   = take && (cnt == CNT_LAST);
    assign sum_re = acc_re + {{CNT_W{bus.Re_in[IN_W-1]}}, bus.Re_in};
    assign sum_im = acc_im + {{CNT_W{bus.Im_in[IN_W-1]}}, bus.Im_in};

    generate
        if (OUT_W >= ACC_W) begin : g_nosat
            // Output is wide enough for any block sum: plain sign extension.
            assign sat_re = OUT_W'(sum_re);
            assign sat_im = OUT_W'(sum_im);
            assign hit_re = 1'b0;
            assign hit_im = 1'b0;
        end else begin : g_sat
            localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'({(OUT_W-1){1'b1}});
            localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
            always_comb begin
                hit_re = 1'b0;
                sat_re = sum_re[OUT_W-1:0];
                if (sum_re > MAX_V) begin
                    hit_re = 1'b1;
                    sat_re = MAX_V[OUT_W-1:0];
                end else if (sum_re < MIN_V) begin
                    hit_re = 1'b1;
                    sat_re = MIN_V[OUT_W-1:0];
                end
            end
            always_comb begin
                hit_im = 1'b0;
                sat_im = sum_im[OUT_W-1:0];
                if (sum_im > MAX_V) begin
                    hit_im = 1'b1;
                    sat_im = MAX_V[OUT_W-1:0];
                end else if (sum_im < MIN_V) begin
                    hit_im = 1'b1;
                    sat_im = MIN_V[OUT_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= '0;
        end else if (bus.acc_clr || dump) begin
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= '0;
        end else if (take) begin
            acc_re <= sum_re;
            acc_im <= sum_im;
            cnt    <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (dump) state_d = FULL;
            FULL:  if (!dump && bus.out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.data_valid_out = (state_q == FULL);
    end

    // Result register; holds its value while EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q      <= '0;
            im_q      <= '0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (dump) begin
                re_q  <= sat_re;
                im_q  <= sat_im;
                sat_q <= hit_re || hit_im;
            end
            // A result still pending when the next one lands is lost.
            if (dump && (state_q == FULL) && !bus.out_ready) overrun_q <= 1'b1;
        end
    end

    assign bus.Re_out   = re_q;
    assign bus.Im_out   = im_q;
    assign bus.sat_flag = sat_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_complex_accumulator.sv
// Directed testbench for complex_accumulator (ACC_LEN=16, IN_W=16, OUT_W=18).
module tb_complex_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    complex_accumulator_if #(.IN_W(16), .OUT_W(18)) bus ();

    complex_accumulator #(.IN_W(16), .OUT_W(18), .ACC_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at 1 time unit after a rising edge; returns at the same offset.
    task automatic feed(input int n, input int re, input int im);
        for (int i = 0; i < n; i++) begin
            bus.Re_in         = 16'(re);
            bus.Im_in         = 16'(im);
            bus.data_valid_in = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.data_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.data_valid_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int sum_re, sum_im, re_v, im_v;

    initial begin
        bus.Re_in         = '0;
        bus.Im_in         = '0;
        bus.data_valid_in = 1'b0;
        bus.acc_clr       = 1'b0;
        bus.out_ready     = 1'b1;

        // Reset values
        #12;
        chk("rst_re", 32'(bus.Re_out), 0);
        chk("rst_im", 32'(bus.Im_out), 0);
        chk("rst_dvo", 32'(bus.data_valid_out), 0);
        chk("rst_sat", 32'(bus.sat_flag), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic block 1000 / -500
        feed(15, 1000, -500);
        chk("basic_dvo_early", 32'(bus.data_valid_out), 0);
        feed(1, 1000, -500);
        chk("basic_dvo", 32'(bus.data_valid_out), 1);
        chk("basic_re", 32'(bus.Re_out), 16000);
        chk("basic_im", 32'(bus.Im_out), -8000);
        chk("basic_sat", 32'(bus.sat_flag), 0);
        idle(1);
        chk("basic_consumed", 32'(bus.data_valid_out), 0);
        chk("basic_hold_re", 32'(bus.Re_out), 16000);

        // Saturation
        feed(16, 32767, -32768);
        chk("sat_dvo", 32'(bus.data_valid_out), 1);
        chk("sat_re", 32'(bus.Re_out), 131071);
        chk("sat_im", 32'(bus.Im_out), -131072);
        chk("sat_flag", 32'(bus.sat_flag), 1);
        idle(1);

        // Overrun with out_ready low
        bus.out_ready = 1'b0;
        feed(16, 1, 0);
        chk("ovr_b1_dvo", 32'(bus.data_valid_out), 1);
        chk("ovr_b1_re", 32'(bus.Re_out), 16);
        chk("ovr_b1_sat", 32'(bus.sat_flag), 0);
        chk("ovr_b1_ovr", 32'(bus.overrun), 0);
        feed(16, 2, 0);
        chk("ovr_b2_re", 32'(bus.Re_out), 32);
        chk("ovr_b2_dvo", 32'(bus.data_valid_out), 1);
        chk("ovr_b2_ovr", 32'(bus.overrun), 1);
        bus.out_ready = 1'b1;
        idle(1);
        chk("ovr_drain_dvo", 32'(bus.data_valid_out), 0);
        chk("ovr_sticky", 32'(bus.overrun), 1);

        // acc_clr discards partial block and the coincident sample
        feed(5, 7, 0);
        bus.Re_in         = 16'(99);
        bus.data_valid_in = 1'b1;
        bus.acc_clr       = 1'b1;
        @(posedge clk);
        #1;
        bus.acc_clr = 1'b0;
        feed(15, 1, 0);
        chk("clr_no_early", 32'(bus.data_valid_out), 0);
        feed(1, 1, 0);
        chk("clr_dvo", 32'(bus.data_valid_out), 1);
        chk("clr_re", 32'(bus.Re_out), 16);
        chk("clr_ovr_kept", 32'(bus.overrun), 1);
        idle(1);

        // Clear the sticky overrun, then gapped input with handover
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("gap_ovr_cleared", 32'(bus.overrun), 0);
        bus.out_ready = 1'b0;
        sum_re = 0;
        sum_im = 0;
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 2));
            re_v = i * 100 - 700;
            im_v = 50 - i * 13;
            sum_re += re_v;
            sum_im += im_v;
            feed(1, re_v, im_v);
        end
        chk("gap_a_dvo", 32'(bus.data_valid_out), 1);
        chk("gap_a_re", 32'(bus.Re_out), sum_re);
        chk("gap_a_im", 32'(bus.Im_out), sum_im);
        sum_re = 0;
        sum_im = 0;
        for (int i = 0; i < 15; i++) begin
            idle($urandom_range(0, 3));
            re_v = 2000 - i * 37;
            im_v = -3 * i - 1;
            sum_re += re_v;
            sum_im += im_v;
            feed(1, re_v, im_v);
        end
        chk("gap_hold_dvo", 32'(bus.data_valid_out), 1);
        chk("gap_hold_re", 32'(bus.Re_out), 16'sd0 + (0 - 700) * 16 + 100 * 120);
        sum_re += 555;
        sum_im += -444;
        bus.out_ready = 1'b1;
        feed(1, 555, -444);
        chk("gap_b_dvo", 32'(bus.data_valid_out), 1);
        chk("gap_b_re", 32'(bus.Re_out), sum_re);
        chk("gap_b_im", 32'(bus.Im_out), sum_im);
        chk("gap_b_ovr", 32'(bus.overrun), 0);
        idle(1);
        chk("gap_b_consumed", 32'(bus.data_valid_out), 0);

        // Asynchronous reset mid-block with a result pending
        bus.out_ready = 1'b0;
        feed(16, 5, 5);
        feed(9, 5, 5);
        chk("arst_pending", 32'(bus.data_valid_out), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_re", 32'(bus.Re_out), 0);
        chk("arst_im", 32'(bus.Im_out), 0);
        chk("arst_dvo", 32'(bus.data_valid_out), 0);
        chk("arst_sat", 32'(bus.sat_flag), 0);
        chk("arst_ovr", 32'(bus.overrun), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        feed(15, 3, 0);
        chk("arst_no_early", 32'(bus.data_valid_out), 0);
        feed(1, 3, 0);
        chk("arst_after_dvo", 32'(bus.data_valid_out), 1);
        chk("arst_after_re", 32'(bus.Re_out), 48);
        chk("arst_after_im", 32'(bus.Im_out), 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
